// File: rtl/fcvt_s_w_seq_if.sv
// Handshake bundle for the integer-to-binary32 converter: operand side,
// result side and the pipeline kill.
interface fcvt_s_w_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             is_unsigned;
    logic [2:0]       rm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [4:0]       out_fflags;

    modport master (
        output flush, in_valid, in_data, is_unsigned, rm, out_ready,
        input  in_ready, out_valid, out_data, out_fflags
    );

    modport slave (
        input  flush, in_valid, in_data, is_unsigned, rm, out_ready,
        output in_ready, out_valid, out_data, out_fflags
    );
endinterface

// File: rtl/fcvt_s_w_seq.sv
// Multi-cycle FCVT.S.W / FCVT.S.WU: shifts the magnitude left one bit per
// cycle until the leading one reaches bit 31, then rounds in a single cycle.
module fcvt_s_w_seq #(
    parameter int WIDTH = 32,
    parameter int BIAS  = 127
) (
    input  logic           clk,
    input  logic           rst,
    fcvt_s_w_seq_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       r_state;
    logic             r_sign;
    logic [WIDTH-1:0] r_mag;
    logic [4:0]       r_exp;
    logic [2:0]       r_rm;
    logic [WIDTH-1:0] r_out_data;
    logic [4:0]       r_out_fflags;

    logic             w_in_sign;
    logic [WIDTH-1:0] w_in_mag;
    logic             w_g;
    logic             w_s;
    logic             w_lsb;
    logic             w_inc;
    logic [23:0]      w_frac_sum;
    logic [7:0]       w_exp_field;

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = (r_state == DONE);
    assign bus.out_data   = r_out_data;
    assign bus.out_fflags = r_out_fflags;

    // 0x80000000 signed negates to itself, which is exactly 2^31 unsigned.
    assign w_in_sign = !bus.is_unsigned & bus.in_data[WIDTH-1];
    assign w_in_mag  = w_in_sign ? (~bus.in_data + 1'b1) : bus.in_data;

    always_comb begin
        w_g   = r_mag[7];
        w_s   = |r_mag[6:0];
        w_lsb = r_mag[8];
        case (r_rm)
            3'b001:  w_inc = 1'b0;
            3'b010:  w_inc = r_sign & (w_g | w_s);
            3'b011:  w_inc = !r_sign & (w_g | w_s);
            3'b100:  w_inc = w_g;
            default: w_inc = w_g & (w_s | w_lsb);
        endcase
        // A carry out of the fraction leaves the low 23 bits at zero.
        w_frac_sum  = {1'b0, r_mag[30:8]} + {23'd0, w_inc};
        w_exp_field = {3'b000, r_exp} + 8'(BIAS) + {7'd0, w_frac_sum[23]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sign       <= 1'b0;
            r_mag        <= '0;
            r_exp        <= '0;
            r_rm         <= '0;
            r_out_data   <= '0;
            r_out_fflags <= '0;
        end else if (bus.flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign <= w_in_sign;
                        r_mag  <= w_in_mag;
                        r_exp  <= 5'd31;
                        r_rm   <= bus.rm;
                        if (w_in_mag == '0) begin
                            r_state      <= DONE;
                            r_out_data   <= '0;
                            r_out_fflags <= '0;
                        end else begin
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (r_mag[WIDTH-1]) begin
                        r_state <= ROUND;
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 5'd1;
                    end
                end
                ROUND: begin
                    r_out_data   <= {r_sign, w_exp_field, w_frac_sum[22:0]};
                    r_out_fflags <= {4'b0000, w_g | w_s};
                    r_state      <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcvt_s_w_seq.sv
// Directed self-checking bench for fcvt_s_w_seq: conversion table, rounding
// ties, backpressure, flush, async reset and handshake corners.
module tb_fcvt_s_w_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   accepts;
    bit   sawValid;

    fcvt_s_w_seq_if #(.WIDTH(32)) busIf ();

    fcvt_s_w_seq #(.WIDTH(32), .BIAS(127)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Accept one operand, measure edges to out_valid, check result, optionally
    // stall in DONE for holdCycles, then complete the output handshake.
    task automatic applyStimulus(input string tag, input logic [31:0] data,
                                 input bit uns, input logic [2:0] mode,
                                 input logic [31:0] expData, input bit expNx,
                                 input int expLat, input int holdCycles);
        int n;
        checkOutput({tag, ".in_ready"}, 32'(busIf.in_ready), 32'd1);
        busIf.in_data     = data;
        busIf.is_unsigned = uns;
        busIf.rm          = mode;
        busIf.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        busIf.in_valid = 1'b0;
        n = 0;
        while (!busIf.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, ".latency"}, 32'(n), 32'(expLat));
        checkOutput({tag, ".data"}, busIf.out_data, expData);
        checkOutput({tag, ".fflags"}, 32'(busIf.out_fflags), {27'd0, 4'b0000, expNx});
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".hold_valid"}, 32'(busIf.out_valid), 32'd1);
            checkOutput({tag, ".hold_data"}, busIf.out_data, expData);
            checkOutput({tag, ".hold_fflags"}, 32'(busIf.out_fflags), {27'd0, 4'b0000, expNx});
            checkOutput({tag, ".hold_in_ready"}, 32'(busIf.in_ready), 32'd0);
        end
        busIf.out_ready = 1'b1;
        @(posedge clk);
        #1;
        busIf.out_ready = 1'b0;
        checkOutput({tag, ".valid_drop"}, 32'(busIf.out_valid), 32'd0);
        checkOutput({tag, ".ready_back"}, 32'(busIf.in_ready), 32'd1);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst               = 1'b1;
        busIf.flush       = 1'b0;
        busIf.in_valid    = 1'b0;
        busIf.in_data     = '0;
        busIf.is_unsigned = 1'b0;
        busIf.rm          = 3'b000;
        busIf.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("reset.out_data", busIf.out_data, 32'd0);
        checkOutput("reset.out_fflags", 32'(busIf.out_fflags), 32'd0);
        checkOutput("reset.in_ready", 32'(busIf.in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] conversion table");
        applyStimulus("one_rne",      32'h0000_0001, 1'b0, 3'b000, 32'h3F80_0000, 1'b0, 33, 0);
        applyStimulus("minus_one",    32'hFFFF_FFFF, 1'b0, 3'b000, 32'hBF80_0000, 1'b0, 33, 0);
        applyStimulus("umax_rne",     32'hFFFF_FFFF, 1'b1, 3'b000, 32'h4F80_0000, 1'b1, 2, 0);
        applyStimulus("umax_rtz",     32'hFFFF_FFFF, 1'b1, 3'b001, 32'h4F7F_FFFF, 1'b1, 2, 0);
        applyStimulus("int_min",      32'h8000_0000, 1'b0, 3'b000, 32'hCF00_0000, 1'b0, 2, 0);
        applyStimulus("zero_w",       32'h0000_0000, 1'b0, 3'b000, 32'h0000_0000, 1'b0, 0, 0);
        applyStimulus("zero_wu",      32'h0000_0000, 1'b1, 3'b011, 32'h0000_0000, 1'b0, 0, 0);
        applyStimulus("minus_seven",  32'hFFFF_FFF9, 1'b0, 3'b000, 32'hC0E0_0000, 1'b0, 31, 0);

        $display("[TB] tie rounding");
        applyStimulus("tie_rne",      32'h0100_0001, 1'b1, 3'b000, 32'h4B80_0000, 1'b1, 9, 0);
        applyStimulus("tie_rtz",      32'h0100_0001, 1'b1, 3'b001, 32'h4B80_0000, 1'b1, 9, 0);
        applyStimulus("tie_rup",      32'h0100_0001, 1'b1, 3'b011, 32'h4B80_0001, 1'b1, 9, 0);
        applyStimulus("tie_rmm",      32'h0100_0001, 1'b1, 3'b100, 32'h4B80_0001, 1'b1, 9, 0);
        applyStimulus("tie_rm101",    32'h0100_0001, 1'b1, 3'b101, 32'h4B80_0000, 1'b1, 9, 0);
        applyStimulus("tie_odd_rne",  32'h0100_0003, 1'b1, 3'b000, 32'h4B80_0002, 1'b1, 9, 0);
        applyStimulus("neg_tie_rdn",  32'hFEFF_FFFF, 1'b0, 3'b010, 32'hCB80_0001, 1'b1, 9, 0);
        applyStimulus("neg_tie_rup",  32'hFEFF_FFFF, 1'b0, 3'b011, 32'hCB80_0000, 1'b1, 9, 0);

        $display("[TB] backpressure");
        applyStimulus("stall",        32'hFFFF_FFFF, 1'b1, 3'b000, 32'h4F80_0000, 1'b1, 2, 5);

        $display("[TB] flush during NORM");
        busIf.in_data     = 32'h0000_0001;
        busIf.is_unsigned = 1'b0;
        busIf.rm          = 3'b000;
        busIf.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        busIf.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        busIf.flush = 1'b1;
        @(posedge clk);
        #1;
        busIf.flush = 1'b0;
        checkOutput("flush.in_ready", 32'(busIf.in_ready), 32'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busIf.out_valid) sawValid = 1'b1;
        end
        checkOutput("flush.no_valid", 32'(sawValid), 32'd0);
        applyStimulus("after_flush",  32'h0000_0002, 1'b0, 3'b000, 32'h4000_0000, 1'b0, 32, 0);

        $display("[TB] async reset during NORM");
        busIf.in_data  = 32'h0000_0001;
        busIf.in_valid = 1'b1;
        @(posedge clk);
        #1;
        busIf.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("areset.out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("areset.in_ready", 32'(busIf.in_ready), 32'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("areset.idle", 32'(busIf.in_ready), 32'd1);
        applyStimulus("after_reset",  32'h8000_0000, 1'b0, 3'b000, 32'hCF00_0000, 1'b0, 2, 0);

        $display("[TB] in_valid held while busy");
        accepts           = 0;
        busIf.in_data     = 32'h8000_0000;
        busIf.is_unsigned = 1'b0;
        busIf.rm          = 3'b000;
        busIf.in_valid    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (busIf.in_ready) accepts++;
            @(posedge clk);
            #1;
        end
        busIf.in_valid = 1'b0;
        checkOutput("held.accepts", 32'(accepts), 32'd1);
        checkOutput("held.out_valid", 32'(busIf.out_valid), 32'd1);
        checkOutput("held.data", busIf.out_data, 32'hCF00_0000);
        busIf.out_ready = 1'b1;
        @(posedge clk);
        #1;
        busIf.out_ready = 1'b0;
        checkOutput("held.ready_back", 32'(busIf.in_ready), 32'd1);

        $display("[TB] in_valid with flush in IDLE");
        busIf.in_data  = 32'h0000_0000;
        busIf.in_valid = 1'b1;
        busIf.flush    = 1'b1;
        @(posedge clk);
        #1;
        busIf.in_valid = 1'b0;
        busIf.flush    = 1'b0;
        checkOutput("flush_accept.out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("flush_accept.in_ready", 32'(busIf.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("flush_accept.still_idle", 32'(busIf.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
